// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RV32I control unit: sequences each instruction through the datapath
// and decodes op/funct3/funct7b5 into the ALU operation code.
module alu_ctrl_fsm #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic       halted
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R   = 7'b0110011,
                         OP_I  = 7'b0010011, OP_B  = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  state_t state, next;
  logic [2:0] alu_op;
  logic       alu_ok, r_ok;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FETCH;
    else     state <= next;

  always_comb begin
    alu_op = ALU_ADD;
    alu_ok = 1'b1;
    case (funct3)
      3'b000:  alu_op = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_ok = 1'b0;
    endcase
    // funct7b5 set is only meaningful for SUB on R-type
    r_ok = alu_ok && (!funct7b5 || funct3 == 3'b000);
  end

  always_comb begin
    next       = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_B:    ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_R:   if (r_ok) next = S_EXECR; else illegal = 1'b1;
          OP_I:   if (alu_ok) next = S_EXECI; else illegal = 1'b1;
          OP_B:   if (funct3 == 3'b000) next = S_BEQ; else illegal = 1'b1;
          OP_JAL: next = S_JAL;
          default: illegal = 1'b1;
        endcase
        if (illegal) next = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op;
        next       = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
        next       = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
        next       = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        next    = S_ALUWB;
      end
      S_HALT: halted = 1'b1;
      default: next = S_FETCH;
    endcase
    // Reset is asynchronous, so outputs are forced quiet directly rather than via state
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      halted     = 1'b0;
    end
  end
endmodule
